// File: rtl/mod_mul_sched_pkg.sv
// Shared types and constants for the modular-multiplier engine scheduler.
package mod_mul_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    ABORT,
    RESP
  } sched_st_e;

  // Number of cycles the engine is held in reset after a watchdog expiry.
  localparam int ABORT_RST_CYC = 2;

  // Default watchdog limit in engine-busy cycles.
  localparam int DEFAULT_TMO = 1 << 20;

endpackage

// File: rtl/mod_mul_sched_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, searching cyclically. Reusable by any engine scheduler.
module rr_arb #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic found;
  int   idx;

  // Cyclic priority scan starting at ptr; first hit wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/mod_mul_sched.sv
// Round-robin scheduler sharing one interleaved modular-multiplier engine
// among NREQ requesters. One operation in flight at a time; operands are
// held stable for the engine, and a watchdog aborts a hung engine.
module mod_mul_sched
  import mod_mul_sched_pkg::*;
#(
  parameter int NBITS = 4096,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ),
  parameter int TMO   = DEFAULT_TMO,
  parameter int TMOW  = 21
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*NBITS-1:0] req_a,
  input  logic [NREQ*NBITS-1:0] req_b,
  input  logic [NREQ*NBITS-1:0] req_m,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [NBITS-1:0]      rsp_y,
  output logic                  rsp_err,
  output logic                  mm_enable_p,
  output logic [NBITS-1:0]      mm_a,
  output logic [NBITS-1:0]      mm_b,
  output logic [NBITS-1:0]      mm_m,
  input  logic [NBITS-1:0]      mm_y,
  input  logic                  mm_done_p,
  output logic                  mm_rst_n,
  output logic                  busy
);

  localparam int ACW = (ABORT_RST_CYC > 1) ? $clog2(ABORT_RST_CYC) : 1;

  sched_st_e         state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NBITS-1:0]  mm_a_q, mm_a_d;
  logic [NBITS-1:0]  mm_b_q, mm_b_d;
  logic [NBITS-1:0]  mm_m_q, mm_m_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [NBITS-1:0]  rsp_y_q, rsp_y_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              mm_enable_p_q, mm_enable_p_d;
  logic              mm_rst_n_q, mm_rst_n_d;
  logic [TMOW-1:0]   wdog_q, wdog_d;
  logic [ACW-1:0]    abort_cnt_q, abort_cnt_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [IDW-1:0]    arb_id;
  logic              accept;

  // Per-requester views of the flattened operand buses.
  logic [NBITS-1:0]  a_arr [NREQ];
  logic [NBITS-1:0]  b_arr [NREQ];
  logic [NBITS-1:0]  m_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*NBITS +: NBITS];
    assign b_arr[gi] = req_b[gi*NBITS +: NBITS];
    assign m_arr[gi] = req_m[gi*NBITS +: NBITS];
  end

  rr_arb #(.NREQ(NREQ)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  // Grant is only offered while idle, so at most one request is in flight.
  assign req_ready = (state_q == IDLE) ? arb_gnt : '0;
  assign accept    = (state_q == IDLE) && (|arb_gnt);
  assign busy      = (state_q != IDLE);

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_y       = rsp_y_q;
  assign rsp_err     = rsp_err_q;
  assign mm_enable_p = mm_enable_p_q;
  assign mm_a        = mm_a_q;
  assign mm_b        = mm_b_q;
  assign mm_m        = mm_m_q;
  assign mm_rst_n    = mm_rst_n_q;

  // Next-state and next-register logic for the scheduler FSM.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    mm_a_d        = mm_a_q;
    mm_b_d        = mm_b_q;
    mm_m_d        = mm_m_q;
    rsp_id_d      = rsp_id_q;
    rsp_y_d       = rsp_y_q;
    rsp_err_d     = rsp_err_q;
    rsp_valid_d   = rsp_valid_q;
    mm_enable_p_d = 1'b0;
    mm_rst_n_d    = 1'b1;
    wdog_d        = wdog_q;
    abort_cnt_d   = abort_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          // Operands are captured once here and never move until the next
          // accept, because the engine samples them late.
          mm_a_d        = a_arr[arb_id];
          mm_b_d        = b_arr[arb_id];
          mm_m_d        = m_arr[arb_id];
          rsp_id_d      = arb_id;
          rr_ptr_d      = (arb_id == IDW'(NREQ - 1)) ? '0 : arb_id + IDW'(1);
          mm_enable_p_d = 1'b1;
          state_d       = LAUNCH;
        end
      end
      LAUNCH: begin
        wdog_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        wdog_d = wdog_q + TMOW'(1);
        // Completion takes priority over a simultaneous watchdog expiry.
        if (mm_done_p) begin
          rsp_y_d     = mm_y;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (wdog_q == TMOW'(TMO - 1)) begin
          abort_cnt_d = '0;
          mm_rst_n_d  = 1'b0;
          state_d     = ABORT;
        end
      end
      ABORT: begin
        mm_rst_n_d  = 1'b0;
        abort_cnt_d = abort_cnt_q + ACW'(1);
        if (abort_cnt_q == ACW'(ABORT_RST_CYC - 1)) begin
          mm_rst_n_d  = 1'b1;
          rsp_y_d     = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset also holds the engine in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      mm_a_q        <= '0;
      mm_b_q        <= '0;
      mm_m_q        <= '0;
      rsp_id_q      <= '0;
      rsp_y_q       <= '0;
      rsp_err_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      mm_enable_p_q <= 1'b0;
      mm_rst_n_q    <= 1'b0;
      wdog_q        <= '0;
      abort_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      mm_a_q        <= mm_a_d;
      mm_b_q        <= mm_b_d;
      mm_m_q        <= mm_m_d;
      rsp_id_q      <= rsp_id_d;
      rsp_y_q       <= rsp_y_d;
      rsp_err_q     <= rsp_err_d;
      rsp_valid_q   <= rsp_valid_d;
      mm_enable_p_q <= mm_enable_p_d;
      mm_rst_n_q    <= mm_rst_n_d;
      wdog_q        <= wdog_d;
      abort_cnt_q   <= abort_cnt_d;
    end
  end

endmodule

// File: doc/mod_mul_sched.md
# mod_mul_sched

Round-robin scheduler that shares one interleaved modular-multiplier engine (`mod_mul_il_gen_area_opt` class: `enable_p` start pulse, `done_irq_p` completion pulse) among `NREQ` requesters. It accepts one request at a time over a valid/ready handshake and holds that request's operands stable for the whole operation. It launches the engine, watches for completion with a watchdog, and returns the result tagged with the requester ID. It sits between the crypto command front-end and the engine instance.

## Interface
- `NBITS`, 4096: operand/modulus width; must match the engine.
- `NREQ`, 4: number of requesters, 2..16.
- `IDW`, `$clog2(NREQ)`: requester ID width.
- `TMO`, 2^20: watchdog limit in engine-busy cycles.
- `TMOW`, 21: watchdog counter width; must satisfy 2^TMOW > TMO.
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept, one-hot or zero.
- `req_a`, `req_b`, `req_m`  in  NREQ*NBITS each  flattened operands; slice i belongs to requester i.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  result accept.
- `rsp_id`  out  IDW  originating requester.
- `rsp_y`  out  NBITS  result a·b mod m.
- `rsp_err`  out  1  set when the watchdog expired; `rsp_y` is 0 in that case.
- `mm_enable_p`  out  1  engine start pulse.
- `mm_a`, `mm_b`, `mm_m`  out  NBITS each  registered engine operands.
- `mm_y`  in  NBITS  engine result.
- `mm_done_p`  in  1  engine completion pulse.
- `mm_rst_n`  out  1  engine reset, active-low; drives the engine's `rst_n`.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- **FSM states:** IDLE, LAUNCH, RUN, ABORT, RESP.
- **IDLE:** grant = first `req_valid` bit at or after `rr_ptr`, searching cyclically. `req_ready[grant]` is asserted combinationally.
- **Acceptance:** on `req_valid & req_ready`:
  - latch the granted operand slices into `mm_a`/`mm_b`/`mm_m`;
  - latch the grant into `rsp_id`;
  - set `rr_ptr` = grant+1 mod NREQ;
  - go to LAUNCH.
- **LAUNCH:** `mm_enable_p` = 1 for exactly this one cycle. Clear the watchdog. Go to RUN.
- **RUN:** the watchdog increments each cycle.
  - `mm_done_p` → capture `mm_y` into `rsp_y`, `rsp_err` = 0, go to RESP.
  - Else, watchdog == TMO-1 → go to ABORT.
  - `mm_done_p` in the same cycle as expiry: done wins.
- **ABORT:** hold `mm_rst_n` = 0 for 2 cycles, then set `rsp_y` = 0, `rsp_err` = 1, go to RESP.
- **RESP:** `rsp_valid` = 1. `rsp_y`, `rsp_id` and `rsp_err` stay stable until `rsp_ready`, then go to IDLE.
- **Stray pulses:** `mm_done_p` outside RUN is ignored.
- **Operand stability:** `mm_a`, `mm_b`, `mm_m` change only on acceptance. The engine samples operands late (after its internal precompute), so they must not move.
- **No pipelining:** `req_ready` is all-zero outside IDLE. The next request cannot be accepted in the cycle that `rsp_ready` is seen.
- **Requester withdrawal:** a requester may drop `req_valid` before it is granted; it then simply loses arbitration.

## Timing
- **Reset values (`rst` high at a clock edge):**
  - state = IDLE, `rr_ptr` = 0;
  - `req_ready` = 0 except the combinational grant in IDLE;
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_y` = 0, `rsp_err` = 0;
  - `mm_enable_p` = 0, `mm_a`/`mm_b`/`mm_m` = 0, `busy` = 0, watchdog = 0.
- **Engine reset during `rst`:** `mm_rst_n` = 0 while `rst` is high and for the first cycle after `rst` drops; it is 1 otherwise, except in ABORT.
- **Reset mid-operation:** abandons the operation. No response is emitted.
- **Cycle-level latency (accept at edge T):**
  - `mm_enable_p` high in cycle T+1;
  - RUN from T+2;
  - `mm_done_p` at edge D → `rsp_valid` high from D+1.
- **Total latency:** from the request handshake to `rsp_valid`, 2 + engine latency + 1 cycles.
- **Timeout path:** `rsp_valid` rises at T+2+TMO+2.
- **Outputs:** all outputs are registered except `req_ready` and `busy`.

## Structure
- **Package `mod_mul_sched_pkg`:**
  - state enum `sched_st_e` (IDLE, LAUNCH, RUN, ABORT, RESP);
  - `ABORT_RST_CYC` = 2;
  - default `TMO`.
- **Sub-module `rr_arb`** (parameter `NREQ`):
  - inputs `req`, `ptr`; outputs one-hot `gnt` and binary `gnt_id`;
  - purely combinational, reusable by other engine schedulers.
- **Top level:** FSM, operand/response registers and watchdog live in `mod_mul_sched`. The engine is instantiated outside it.

## Test plan
- **Single request:** NREQ=4, NBITS=16, requester 2 sends a=7, b=9, m=13. Expect `mm_enable_p` exactly 1 cycle after accept; response `rsp_id`=2, `rsp_y`=11, `rsp_err`=0.
- **Round-robin fairness:** all 4 requesters held valid for 8 operations. Grant order is 0,1,2,3,0,1,2,3, and `rsp_id` follows the same order.
- **Backpressure:** `rsp_ready` low for 20 cycles after `rsp_valid`. `rsp_*` is stable, `req_ready` = 0 throughout, and the next accept happens the cycle after `rsp_ready`.
- **Watchdog expiry:** stub engine never pulses done, TMO=64. Expect `mm_rst_n` low for 2 cycles at T+66; response `rsp_err`=1, `rsp_y`=0. A following request completes normally.
- **Done/expiry collision:** `mm_done_p` arrives on the expiry cycle. Expect a normal result with `rsp_err`=0 and no `mm_rst_n` pulse.
- **Reset mid-run:** `rst` asserted 5 cycles into RUN. All outputs take their reset values, no `rsp_valid` appears, and `rr_ptr` = 0, so the next grant goes to requester 0.
